// File: rtl/mem_port_arbiter_if.sv
// Bundle between the pipeline/memory side and the memory port arbiter.
// The arbiter uses the slave modport; the pipeline and memory model drive the master side.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_rdata, if_valid, dm_rdata, dm_valid, mem_req, mem_we, mem_addr, mem_wdata,
    output stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_valid, dm_rdata, dm_valid, mem_req, mem_we, mem_addr, mem_wdata,
    input  stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares a single-ported memory between instruction fetch and the MEM stage, one transaction
// at a time; MEM has priority but a starvation counter forces an IF grant after STARVE_MAX.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus_io
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    StIdle,
    StServeDm,
    StServeIf,
    StResp
  } state_e;

  state_e            state_q;
  logic [3:0]        starve_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              if_valid_q;
  logic              dm_valid_q;

  logic starve_hit;
  logic grant_dm;
  logic grant_if;

  always_comb begin
    starve_hit = bus_io.if_req && (starve_q == StarveMax);
    grant_dm   = (state_q == StIdle) && bus_io.dm_req && !starve_hit;
    grant_if   = (state_q == StIdle) && !grant_dm && bus_io.if_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;

      // Counts DM grants that overtook a pending fetch; any IF grant or idle IF clears it.
      if (!bus_io.if_req || grant_if) begin
        starve_q <= '0;
      end else if (grant_dm && (starve_q != StarveMax)) begin
        starve_q <= starve_q + 4'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (grant_dm) begin
            state_q     <= StServeDm;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus_io.dm_we;
            mem_addr_q  <= bus_io.dm_addr;
            mem_wdata_q <= bus_io.dm_wdata;
          end else if (grant_if) begin
            state_q     <= StServeIf;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus_io.if_addr;
            mem_wdata_q <= '0;
          end
        end
        StServeDm: begin
          if (bus_io.mem_ready) begin
            if (!mem_we_q) begin
              dm_rdata_q <= bus_io.mem_rdata;
            end
            dm_valid_q <= 1'b1;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            state_q    <= StResp;
          end
        end
        StServeIf: begin
          if (bus_io.mem_ready) begin
            if_rdata_q <= bus_io.mem_rdata;
            if_valid_q <= 1'b1;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            state_q    <= StResp;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus_io.mem_req   = mem_req_q;
  assign bus_io.mem_we    = mem_we_q;
  assign bus_io.mem_addr  = mem_addr_q;
  assign bus_io.mem_wdata = mem_wdata_q;
  assign bus_io.if_rdata  = if_rdata_q;
  assign bus_io.if_valid  = if_valid_q;
  assign bus_io.dm_rdata  = dm_rdata_q;
  assign bus_io.dm_valid  = dm_valid_q;
  assign bus_io.stall_if  = bus_io.if_req & ~if_valid_q;
  assign bus_io.stall_mem = bus_io.dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table plus hand-written sequences
// for contention, starvation and reset during a transaction.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .STARVE_MAX(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  // exp = {mem_req, mem_we, mem_addr, mem_wdata, if_valid, dm_valid, stall_if, stall_mem,
  //        if_rdata, dm_rdata}
  typedef struct {
    logic        if_req;
    logic [11:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [11:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic [65:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   overlaps = 0;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.if_valid === 1'b1 && bus.dm_valid === 1'b1) overlaps++;
  end

  task automatic add(input int unsigned ir, ia, dr, dwe, da, dwd, rdy, rd,
                     input int unsigned e_req, e_we, e_a, e_wd, e_iv, e_dv, e_si, e_sm,
                     input int unsigned e_ird, e_drd);
    vec_t v;
    v.if_req    = 1'(ir);
    v.if_addr   = 12'(ia);
    v.dm_req    = 1'(dr);
    v.dm_we     = 1'(dwe);
    v.dm_addr   = 12'(da);
    v.dm_wdata  = 16'(dwd);
    v.mem_ready = 1'(rdy);
    v.mem_rdata = 16'(rd);
    v.exp = {1'(e_req), 1'(e_we), 12'(e_a), 16'(e_wd), 1'(e_iv), 1'(e_dv), 1'(e_si),
             1'(e_sm), 16'(e_ird), 16'(e_drd)};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [65:0] outs();
    return {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.if_valid, bus.dm_valid,
            bus.stall_if, bus.stall_mem, bus.if_rdata, bus.dm_rdata};
  endfunction

  task automatic drive_idle();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
  endtask

  initial begin
    logic [11:0] grants[$];
    logic [5:0]  pat;
    logic        prev_req;
    logic        first_dm;
    logic        seen_first;
    logic        if_done;
    logic        reached;

    // Reset state, IF fetch with two wait cycles
    add(0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 'h010, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 'h010, 0, 0, 0, 0, 0, 0,        1, 0, 'h010, 0, 0, 0, 1, 0, 0, 0);
    add(1, 'h010, 0, 0, 0, 0, 0, 0,        1, 0, 'h010, 0, 0, 0, 1, 0, 0, 0);
    add(1, 'h010, 0, 0, 0, 0, 1, 'hA5A5,   1, 0, 'h010, 0, 0, 0, 1, 0, 0, 0);
    add(1, 'h010, 0, 0, 0, 0, 0, 0,        0, 0, 'h010, 0, 1, 0, 0, 0, 'hA5A5, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 'h010, 0, 0, 0, 0, 0, 'hA5A5, 0);
    // Load 0x030 -> 0x5A5A
    add(0, 0, 1, 0, 'h030, 0, 0, 0,        0, 0, 'h010, 0, 0, 0, 0, 1, 'hA5A5, 0);
    add(0, 0, 1, 0, 'h030, 0, 1, 'h5A5A,   1, 0, 'h030, 0, 0, 0, 0, 1, 'hA5A5, 0);
    add(0, 0, 1, 0, 'h030, 0, 0, 0,        0, 0, 'h030, 0, 0, 1, 0, 0, 'hA5A5, 'h5A5A);
    // Store 0x1234 to 0x020; dm_rdata must not take mem_rdata
    add(0, 0, 1, 1, 'h020, 'h1234, 0, 0,   0, 0, 'h030, 0, 0, 0, 0, 1, 'hA5A5, 'h5A5A);
    add(0, 0, 1, 1, 'h020, 'h1234, 1, 'hFFFF,
        1, 1, 'h020, 'h1234, 0, 0, 0, 1, 'hA5A5, 'h5A5A);
    add(0, 0, 1, 1, 'h020, 'h1234, 0, 0,   0, 0, 'h020, 'h1234, 0, 1, 0, 0, 'hA5A5, 'h5A5A);
    add(0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 'h020, 'h1234, 0, 0, 0, 0, 'hA5A5, 'h5A5A);
    // Address latch: dm_addr changes to 0x3FF while served
    add(0, 0, 1, 0, 'h020, 0, 0, 0,        0, 0, 'h020, 'h1234, 0, 0, 0, 1, 'hA5A5, 'h5A5A);
    add(0, 0, 1, 0, 'h3FF, 0, 0, 0,        1, 0, 'h020, 0, 0, 0, 0, 1, 'hA5A5, 'h5A5A);
    add(0, 0, 1, 0, 'h3FF, 0, 0, 0,        1, 0, 'h020, 0, 0, 0, 0, 1, 'hA5A5, 'h5A5A);
    add(0, 0, 1, 0, 'h3FF, 0, 1, 'h0BEE,   1, 0, 'h020, 0, 0, 0, 0, 1, 'hA5A5, 'h5A5A);
    add(0, 0, 1, 0, 'h3FF, 0, 0, 0,        0, 0, 'h020, 0, 0, 1, 0, 0, 'hA5A5, 'h0BEE);
    add(0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 'h020, 0, 0, 0, 0, 0, 'hA5A5, 'h0BEE);

    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      bus.if_req    = vecs[i].if_req;
      bus.if_addr   = vecs[i].if_addr;
      bus.dm_req    = vecs[i].dm_req;
      bus.dm_we     = vecs[i].dm_we;
      bus.dm_addr   = vecs[i].dm_addr;
      bus.dm_wdata  = vecs[i].dm_wdata;
      bus.mem_ready = vecs[i].mem_ready;
      bus.mem_rdata = vecs[i].mem_rdata;
      #1;
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Contention: DM wins, IF served next
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 12'h011;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 12'h200;
    bus.mem_ready = 1'b1; bus.mem_rdata = 16'h1111;
    prev_req = 1'b0; seen_first = 1'b0; first_dm = 1'b0; if_done = 1'b0;
    for (int c = 0; c < 40 && !if_done; c++) begin
      #1;
      if (bus.mem_req && !prev_req) grants.push_back(bus.mem_addr);
      prev_req = bus.mem_req;
      if (bus.dm_valid) begin
        if (!seen_first) first_dm = 1'b1;
        seen_first = 1'b1;
        bus.dm_req = 1'b0;
      end
      if (bus.if_valid) begin
        seen_first = 1'b1;
        if_done = 1'b1;
        bus.if_req = 1'b0;
      end
      @(negedge clk);
    end
    check("contention_done", 66'(if_done), 66'(1));
    check("contention_grant0", 66'(grants.size() > 0 ? grants[0] : 12'hFFF), 66'(12'h200));
    check("contention_grant1", 66'(grants.size() > 1 ? grants[1] : 12'hFFF), 66'(12'h011));
    check("contention_dm_first", 66'(first_dm), 66'(1));

    // Starvation with STARVE_MAX=2: DM DM IF DM DM IF
    drive_idle();
    repeat (2) @(negedge clk);
    grants.delete();
    bus.if_req = 1'b1; bus.if_addr = 12'h011;
    bus.dm_req = 1'b1; bus.dm_addr = 12'h100;
    bus.mem_ready = 1'b1;
    prev_req = 1'b0; pat = '0;
    for (int c = 0; c < 60 && grants.size() < 6; c++) begin
      #1;
      if (bus.mem_req && !prev_req) begin
        grants.push_back(bus.mem_addr);
        pat = {pat[4:0], bus.mem_addr == 12'h100};
      end
      prev_req = bus.mem_req;
      @(negedge clk);
    end
    check("starve_order", 66'({3'(grants.size()), pat}), 66'({3'd6, 6'b110110}));
    drive_idle();
    bus.mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("no_valid_overlap", 66'(overlaps), 66'(0));

    // Reset while serving a DM access
    drive_idle();
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 12'h055; bus.dm_wdata = 16'h7777;
    reached = 1'b0;
    for (int c = 0; c < 10 && !reached; c++) begin
      @(negedge clk);
      #1;
      reached = bus.mem_req;
    end
    check("reset_reached_serve", 66'({reached, bus.mem_we}), 66'(2'b11));
    rst_n = 1'b0;
    #1;
    check("reset_async_memreq", 66'({bus.mem_req, bus.mem_we}), 66'(0));
    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("reset_release_outs", outs(), 66'(0));
    bus.if_req = 1'b1; bus.if_addr = 12'h0AB;
    @(negedge clk);
    #1;
    check("reset_then_grant", 66'({bus.mem_req, bus.mem_addr}), 66'({1'b1, 12'h0AB}));
    bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
